// File: rtl/axi_lite_arbiter2_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream sides.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter2.sv
// Two-master to one-slave AXI4-Lite arbiter, one outstanding transaction, round-robin.
// Define ARB_FIXED_PRIO_EN to make m1 always win ties (no prio register).
module axi_lite_arbiter2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t state;
  logic   gnt;
  logic   is_wr;
  logic   aw_done;
  logic   w_done;

  logic [31:0] sel_araddr, sel_awaddr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;

  assign sel_araddr  = gnt ? m1.araddr  : m0.araddr;
  assign sel_arvalid = gnt ? m1.arvalid : m0.arvalid;
  assign sel_rready  = gnt ? m1.rready  : m0.rready;
  assign sel_awaddr  = gnt ? m1.awaddr  : m0.awaddr;
  assign sel_awvalid = gnt ? m1.awvalid : m0.awvalid;
  assign sel_wdata   = gnt ? m1.wdata   : m0.wdata;
  assign sel_wstrb   = gnt ? m1.wstrb   : m0.wstrb;
  assign sel_wvalid  = gnt ? m1.wvalid  : m0.wvalid;
  assign sel_bready  = gnt ? m1.bready  : m0.bready;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = (state == RD_ADDR) & sel_arvalid & s.arready;
  assign r_hs  = (state == RD_DATA) & s.rvalid & sel_rready;
  assign aw_hs = (state == WR_REQ) & sel_awvalid & ~aw_done & s.awready;
  assign w_hs  = (state == WR_REQ) & sel_wvalid & ~w_done & s.wready;
  assign b_hs  = (state == WR_RESP) & s.bvalid & sel_bready;

  logic req0, req1, tie_win, win, win_is_wr;
  assign req0 = m0.arvalid | m0.awvalid;
  assign req1 = m1.arvalid | m1.awvalid;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_win = 1'b1;
`else
  logic prio;
  logic txn_done;
  assign tie_win  = prio;
  assign txn_done = is_wr ? b_hs : r_hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio <= RR_INIT;
    else if (txn_done) prio <= ~gnt;
  end
`endif

  // A write request from the winning master beats its own pending read.
  assign win       = (req0 & req1) ? tie_win : req1;
  assign win_is_wr = win ? m1.awvalid : m0.awvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      is_wr   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt   <= win;
            is_wr <= win_is_wr;
            state <= win_is_wr ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: if (r_hs) state <= IDLE;
        WR_REQ: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic        up_arready, up_rvalid, up_awready, up_wready, up_bvalid;
  logic [31:0] up_rdata;
  logic [1:0]  up_rresp, up_bresp;

  // Downstream and upstream-return paths are only opened for the active phase.
  always_comb begin
    s.araddr   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wstrb    = '0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    up_arready = 1'b0;
    up_rvalid  = 1'b0;
    up_rdata   = '0;
    up_rresp   = '0;
    up_awready = 1'b0;
    up_wready  = 1'b0;
    up_bvalid  = 1'b0;
    up_bresp   = '0;
    case (state)
      RD_ADDR: begin
        s.araddr   = sel_araddr;
        s.arvalid  = sel_arvalid;
        up_arready = s.arready;
      end
      RD_DATA: begin
        s.rready  = sel_rready;
        up_rvalid = s.rvalid;
        up_rdata  = s.rdata;
        up_rresp  = s.rresp;
      end
      WR_REQ: begin
        s.awaddr   = sel_awaddr;
        s.awvalid  = sel_awvalid & ~aw_done;
        s.wdata    = sel_wdata;
        s.wstrb    = sel_wstrb;
        s.wvalid   = sel_wvalid & ~w_done;
        up_awready = s.awready & ~aw_done;
        up_wready  = s.wready & ~w_done;
      end
      WR_RESP: begin
        s.bready  = sel_bready;
        up_bvalid = s.bvalid;
        up_bresp  = s.bresp;
      end
      default: ;
    endcase
  end

  assign m0.arready = ~gnt & up_arready;
  assign m0.rvalid  = ~gnt & up_rvalid;
  assign m0.rdata   = gnt ? '0 : up_rdata;
  assign m0.rresp   = gnt ? '0 : up_rresp;
  assign m0.awready = ~gnt & up_awready;
  assign m0.wready  = ~gnt & up_wready;
  assign m0.bvalid  = ~gnt & up_bvalid;
  assign m0.bresp   = gnt ? '0 : up_bresp;

  assign m1.arready = gnt & up_arready;
  assign m1.rvalid  = gnt & up_rvalid;
  assign m1.rdata   = gnt ? up_rdata : '0;
  assign m1.rresp   = gnt ? up_rresp : '0;
  assign m1.awready = gnt & up_awready;
  assign m1.wready  = gnt & up_wready;
  assign m1.bvalid  = gnt & up_bvalid;
  assign m1.bresp   = gnt ? up_bresp : '0;

endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// Directed self-checking bench for axi_lite_arbiter2 (default round-robin build, RR_INIT = 0).
module tb_axi_lite_arbiter2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  axi_lite_if m0_bus ();
  axi_lite_if m1_bus ();
  axi_lite_if s_bus ();

  axi_lite_arbiter2 #(.RR_INIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs;
    m0_bus.araddr = '0; m0_bus.arvalid = 0; m0_bus.rready = 0;
    m0_bus.awaddr = '0; m0_bus.awvalid = 0; m0_bus.wdata = '0;
    m0_bus.wstrb = '0; m0_bus.wvalid = 0; m0_bus.bready = 0;
    m1_bus.araddr = '0; m1_bus.arvalid = 0; m1_bus.rready = 0;
    m1_bus.awaddr = '0; m1_bus.awvalid = 0; m1_bus.wdata = '0;
    m1_bus.wstrb = '0; m1_bus.wvalid = 0; m1_bus.bready = 0;
    s_bus.arready = 0; s_bus.rdata = '0; s_bus.rresp = '0; s_bus.rvalid = 0;
    s_bus.awready = 0; s_bus.wready = 0; s_bus.bresp = '0; s_bus.bvalid = 0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear_inputs();
    #1;
    // Reset state: everything quiet even when requests and readies are present.
    m0_bus.arvalid = 1; s_bus.arready = 1; s_bus.rvalid = 1;
    #1;
    check_output("rst_s_arvalid", s_bus.arvalid, 0);
    check_output("rst_m0_arready", m0_bus.arready, 0);
    check_output("rst_m0_rvalid", m0_bus.rvalid, 0);
    apply_reset();

    // Single read from m0, no contention.
    m0_bus.arvalid = 1; m0_bus.araddr = 32'ha00003f8; m0_bus.rready = 1;
    #1;
    check_output("rd_idle_latency", s_bus.arvalid, 0);
    tick();
    check_output("rd_s_arvalid", s_bus.arvalid, 1);
    check_output("rd_s_araddr", s_bus.araddr, 32'ha00003f8);
    check_output("rd_m0_arready_wait", m0_bus.arready, 0);
    tick();
    s_bus.arready = 1;
    #1;
    check_output("rd_m0_arready", m0_bus.arready, 1);
    check_output("rd_m1_arready", m1_bus.arready, 0);
    tick();
    m0_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0; s_bus.rresp = 2'd0;
    #1;
    check_output("rd_s_arvalid_done", s_bus.arvalid, 0);
    check_output("rd_m0_rvalid", m0_bus.rvalid, 1);
    check_output("rd_m0_rdata", m0_bus.rdata, 32'h0);
    check_output("rd_s_rready", s_bus.rready, 1);
    check_output("rd_m1_rvalid", m1_bus.rvalid, 0);
    tick();
    s_bus.rvalid = 0;
    #1;
    check_output("rd_back_idle", s_bus.rready, 0);

    // m1 write with W presented one cycle before AW.
    m1_bus.wvalid = 1; m1_bus.wdata = 32'h41; m1_bus.wstrb = 4'hf; m1_bus.bready = 1;
    #1;
    check_output("wr_w_only_no_req", s_bus.wvalid, 0);
    tick();
    m1_bus.awvalid = 1; m1_bus.awaddr = 32'ha00003f8;
    #1;
    check_output("wr_idle_latency", s_bus.awvalid, 0);
    tick();
    s_bus.wready = 1;
    #1;
    check_output("wr_s_wvalid", s_bus.wvalid, 1);
    check_output("wr_s_wdata", s_bus.wdata, 32'h41);
    check_output("wr_m1_wready", m1_bus.wready, 1);
    check_output("wr_s_awvalid", s_bus.awvalid, 1);
    check_output("wr_m1_awready_wait", m1_bus.awready, 0);
    check_output("wr_m0_wready", m0_bus.wready, 0);
    tick();
    s_bus.awready = 1;
    #1;
    check_output("wr_no_dup_w", s_bus.wvalid, 0);
    check_output("wr_m1_wready_done", m1_bus.wready, 0);
    check_output("wr_s_awaddr", s_bus.awaddr, 32'ha00003f8);
    check_output("wr_m1_awready", m1_bus.awready, 1);
    tick();
    m1_bus.awvalid = 0; m1_bus.wvalid = 0; s_bus.awready = 0; s_bus.wready = 0;
    s_bus.bvalid = 1; s_bus.bresp = 2'd0;
    #1;
    check_output("wr_s_awvalid_done", s_bus.awvalid, 0);
    check_output("wr_s_bready", s_bus.bready, 1);
    check_output("wr_m1_bvalid", m1_bus.bvalid, 1);
    check_output("wr_m1_bresp", m1_bus.bresp, 0);
    check_output("wr_m0_bvalid", m0_bus.bvalid, 0);
    tick();
    s_bus.bvalid = 0;
    #1;
    check_output("wr_back_idle", s_bus.bready, 0);

    // Contention right after reset: m0 read wins, m1 write waits with valids held.
    apply_reset();
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h80000000; m0_bus.rready = 1;
    m1_bus.awvalid = 1; m1_bus.awaddr = 32'ha00003f8;
    m1_bus.wvalid = 1; m1_bus.wdata = 32'h55; m1_bus.wstrb = 4'hf; m1_bus.bready = 1;
    tick();
    s_bus.awready = 1; s_bus.arready = 1;
    #1;
    check_output("ct1_s_arvalid", s_bus.arvalid, 1);
    check_output("ct1_s_araddr", s_bus.araddr, 32'h80000000);
    check_output("ct1_s_awvalid", s_bus.awvalid, 0);
    check_output("ct1_m1_awready", m1_bus.awready, 0);
    check_output("ct1_m0_arready", m0_bus.arready, 1);
    tick();
    m0_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'hcafe0001;
    #1;
    check_output("ct1_m0_rdata", m0_bus.rdata, 32'hcafe0001);
    check_output("ct1_m1_rdata", m1_bus.rdata, 32'h0);
    tick();
    s_bus.rvalid = 0;
    #1;
    check_output("ct1_idle_gap", m1_bus.awready, 0);
    tick();
    s_bus.wready = 1;
    #1;
    check_output("ct1_m1_s_awaddr", s_bus.awaddr, 32'ha00003f8);
    check_output("ct1_m1_awready", m1_bus.awready, 1);
    check_output("ct1_m1_wready", m1_bus.wready, 1);
    tick();
    m1_bus.awvalid = 0; m1_bus.wvalid = 0; s_bus.awready = 0; s_bus.wready = 0;
    s_bus.bvalid = 1; s_bus.bresp = 2'd2;
    #1;
    check_output("ct1_m1_bvalid", m1_bus.bvalid, 1);
    check_output("ct1_m1_bresp_passthru", m1_bus.bresp, 2);
    tick();
    s_bus.bvalid = 0;
    // Second tie: prio returned to m0 after m1 was served.
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h80000004;
    m1_bus.awvalid = 1;
    tick();
    #1;
    check_output("ct2_s_arvalid", s_bus.arvalid, 1);
    check_output("ct2_s_araddr", s_bus.araddr, 32'h80000004);
    check_output("ct2_s_awvalid", s_bus.awvalid, 0);

    // Same-master precedence: m1 write completes before its read goes out.
    apply_reset();
    m1_bus.awvalid = 1; m1_bus.awaddr = 32'ha0000020; m1_bus.wvalid = 1;
    m1_bus.wdata = 32'h77; m1_bus.bready = 1;
    m1_bus.arvalid = 1; m1_bus.araddr = 32'ha0000010; m1_bus.rready = 1;
    tick();
    s_bus.awready = 1; s_bus.wready = 1; s_bus.arready = 1;
    #1;
    check_output("pr_s_awvalid", s_bus.awvalid, 1);
    check_output("pr_s_arvalid", s_bus.arvalid, 0);
    check_output("pr_m1_arready", m1_bus.arready, 0);
    tick();
    m1_bus.awvalid = 0; m1_bus.wvalid = 0; s_bus.awready = 0; s_bus.wready = 0;
    s_bus.bvalid = 1;
    #1;
    check_output("pr_m1_bvalid", m1_bus.bvalid, 1);
    check_output("pr_s_arvalid_in_b", s_bus.arvalid, 0);
    tick();
    s_bus.bvalid = 0;
    #1;
    check_output("pr_idle_gap", s_bus.arvalid, 0);
    tick();
    check_output("pr_s_arvalid_rd", s_bus.arvalid, 1);
    check_output("pr_s_araddr", s_bus.araddr, 32'ha0000010);
    check_output("pr_m1_arready", m1_bus.arready, 1);
    tick();
    m1_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h00005a5a;
    #1;
    check_output("pr_m1_rdata", m1_bus.rdata, 32'h00005a5a);
    check_output("pr_m0_rvalid", m0_bus.rvalid, 0);
    tick();
    s_bus.rvalid = 0;

    // Back-pressured read response to m0.
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h80000040; m0_bus.rready = 0;
    tick();
    s_bus.arready = 1;
    tick();
    m0_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h12345678; s_bus.rresp = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("bp_s_rready_low", s_bus.rready, 0);
      check_output("bp_m0_rvalid_held", m0_bus.rvalid, 1);
      tick();
    end
    m0_bus.rready = 1;
    #1;
    check_output("bp_s_rready", s_bus.rready, 1);
    check_output("bp_m0_rdata", m0_bus.rdata, 32'h12345678);
    tick();
    s_bus.rvalid = 0;
    #1;
    check_output("bp_back_idle", s_bus.rready, 0);

    // Async reset in WR_REQ after AW has completed.
    m0_bus.rready = 0;
    m0_bus.awvalid = 1; m0_bus.awaddr = 32'ha0000100; m0_bus.wvalid = 1;
    m0_bus.wdata = 32'h99; m0_bus.bready = 1;
    tick();
    s_bus.awready = 1;
    tick();
    s_bus.awready = 0; s_bus.wready = 1;
    #1;
    check_output("ar_aw_done_gate", s_bus.awvalid, 0);
    check_output("ar_s_wvalid_pre", s_bus.wvalid, 1);
    check_output("ar_m0_wready_pre", m0_bus.wready, 1);
    reset = 1'b0;
    #1;
    check_output("ar_s_wvalid_rst", s_bus.wvalid, 0);
    check_output("ar_m0_wready_rst", m0_bus.wready, 0);
    check_output("ar_s_bready_rst", s_bus.bready, 0);
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h00000100; m0_bus.rready = 1;
    #1;
    check_output("ar_idle_after", s_bus.awvalid, 0);
    tick();
    s_bus.arready = 1;
    #1;
    check_output("ar_new_s_araddr", s_bus.araddr, 32'h00000100);
    check_output("ar_new_m0_arready", m0_bus.arready, 1);
    tick();
    m0_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000abcd;
    #1;
    check_output("ar_new_m0_rdata", m0_bus.rdata, 32'h0000abcd);
    tick();
    s_bus.rvalid = 0;
    #1;
    check_output("ar_new_idle", s_bus.rready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter2.md
Name: axi_lite_arbiter2

Overview:
- Two-master to one-slave AXI4-Lite arbiter.
- Lets the IFU-side master (m0) and LSU-side master (m1) share one downstream AXI4-Lite slave, such as the UART or the memory slave.
- Allows exactly one outstanding transaction (read or write) at a time.
- Chooses between masters round-robin; responses go back only to the granted master.

Parameters:
- RR_INIT, default 0: master that has priority first after reset (0 = m0, 1 = m1).

Ports:
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset. Block is in reset while reset == 0.
- m0  axi_lite_if.slave  interface  upstream master 0 (IFU).
- m1  axi_lite_if.slave  interface  upstream master 1 (LSU).
- s  axi_lite_if.master  interface  downstream shared slave.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registers:
  - gnt: 1 bit, granted master.
  - is_wr
  - aw_done, w_done
  - prio: 1 bit, preferred master.
- Reset (async assert, sync release to IDLE):
  - state = IDLE, gnt = 0, prio = RR_INIT, aw_done = w_done = 0.
  - Downstream outputs low: s.arvalid, s.awvalid, s.wvalid, s.rready, s.bready.
  - Upstream outputs low: m*.arready, awready, wready, rvalid, bvalid.
  - All forwarded addr/data/resp = 0.
- Reset mid-transaction abandons it; no response is delivered to either master.
- Request detection in IDLE: req_k = mk.arvalid | mk.awvalid.
  - Both request: the master equal to prio wins.
  - One requests: that master wins.
- Within the winning master, awvalid takes precedence over arvalid (is_wr = mk.awvalid).
- IDLE -> WR_REQ (is_wr = 1) or RD_ADDR (is_wr = 0) on the next edge; gnt is latched.
- No downstream valid is driven in IDLE: one cycle of arbitration latency, so the s valid appears in cycle N+1 after the request is seen in cycle N.
- RD_ADDR:
  - s.araddr = m[gnt].araddr, s.arvalid = m[gnt].arvalid, m[gnt].arready = s.arready.
  - On s.arvalid & s.arready -> RD_DATA.
- RD_DATA:
  - s.rready = m[gnt].rready; m[gnt].rvalid/rdata/rresp = s.rvalid/rdata/rresp.
  - On the s.rvalid & s.rready handshake -> IDLE, and prio = ~gnt.
- WR_REQ:
  - s.awvalid = m[gnt].awvalid & ~aw_done.
  - s.wvalid = m[gnt].wvalid & ~w_done.
  - awaddr and wdata are forwarded; readies are passed back, gated by the done flags.
  - aw_done and w_done are set on their respective handshakes.
  - Moves to WR_RESP when both are complete, counting same-cycle handshakes; any order is allowed, including W before AW.
  - Both done flags clear on entry to WR_RESP.
- WR_RESP:
  - s.bready = m[gnt].bready; m[gnt].bvalid/bresp = s.bvalid/bresp.
  - On the handshake -> IDLE, prio = ~gnt.
- Isolation rules:
  - The non-granted master sees all ready/valid low and data 0.
  - The non-granted master's requests stay pending. Valids must be held per AXI; no request is dropped.
  - In RD_*, s.aw*/w*/bready are 0. In WR_*, s.ar*/rready are 0.
- Responses (rresp/bresp) pass through unmodified; the arbiter never generates errors.
- Fairness:
  - With both masters continuously requesting, grants alternate 0,1,0,1… starting at RR_INIT.
  - A lone requester may be granted back-to-back, with one IDLE cycle between transactions.

Optional Feature:
- ARB_FIXED_PRIO_EN.
- Defined: prio is ignored and m1 (LSU) always wins a tie. The prio register is not implemented and RR_INIT has no effect.
- Undefined: round-robin exactly as above.

Test Plan:
- Single read, no contention:
  - Stimulus: m0 ar 0xa00003f8; slave arready after 2 cycles, rdata 0x00000000, rresp 0.
  - Expected: m0 receives rvalid with rdata 0 and rresp 0; state returns to IDLE one cycle after the r handshake; m1 sees no activity.
- Write, W before AW:
  - Stimulus: m1 wvalid wdata 0x00000041 one cycle before awvalid awaddr 0xa00003f8; slave bresp 0.
  - Expected: exactly one s write of 0x41 to 0xa00003f8; m1 gets bvalid, bresp 0; no duplicate W.
- Contention:
  - Stimulus: m0 ar 0x80000000 and m1 aw 0xa00003f8 asserted in the same cycle after reset (RR_INIT = 0).
  - Expected: m0 is served first, then m1, and m1's valids stay held meanwhile. A second tie is then won by m0 again because prio has flipped; with ARB_FIXED_PRIO_EN, m1 wins both ties.
- Same-master write precedence:
  - Stimulus: m1 asserts awvalid+wvalid and arvalid together.
  - Expected: the write completes (B) before s.arvalid is driven for m1's read.
- Back-pressured response:
  - Stimulus: s.rvalid held 3 cycles while m0.rready = 0.
  - Expected: s.rready = 0 for those cycles; the arbiter stays in RD_DATA; rdata 0x12345678 is delivered intact once rready = 1.
- Async reset mid-op:
  - Stimulus: reset driven low during WR_REQ with aw_done = 1, then released.
  - Expected: all valid/ready outputs go low immediately, before the next clk edge; after release the block is in IDLE and a new m0 read completes normally.
